// File: rtl/rv_core_pkg.sv
// Shared core types for the register-hazard scoreboard: register/FU index
// widths and the functional-unit enumeration.
package rv_core_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = $clog2(NUM_REGS);
  localparam int NUM_FU   = 4;
  localparam int FU_W     = $clog2(NUM_FU);

  typedef logic [FU_W-1:0]   fu_idx_t;
  typedef logic [REG_AW-1:0] reg_idx_t;

  typedef enum logic [FU_W-1:0] {
    FU_ALU = 2'd0,
    FU_LSU = 2'd1,
    FU_MUL = 2'd2,
    FU_DIV = 2'd3
  } fu_e;

endpackage

// File: rtl/sb_fu_slot.sv
// One functional-unit slot: remembers whether the FU holds an instruction,
// which register it will write, and whether it writes at all.
module sb_fu_slot
  import rv_core_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_flush,
  input  logic     i_set,
  input  reg_idx_t i_set_rd,
  input  logic     i_set_wr,
  input  logic     i_wb,
  output logic     o_busy,
  output reg_idx_t o_dst,
  output logic     o_wr
);

  logic     r_busy;
  reg_idx_t r_dst;
  logic     r_wr;

  // A new issue into this slot may coincide with its own writeback; the issue wins.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
      r_dst  <= '0;
      r_wr   <= 1'b0;
    end else if (i_flush) begin
      r_busy <= 1'b0;
    end else if (i_set) begin
      r_busy <= 1'b1;
      r_dst  <= i_set_rd;
      r_wr   <= i_set_wr;
    end else if (i_wb) begin
      r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_dst  = r_dst;
  assign o_wr   = r_wr;

endmodule

// File: rtl/rv_scoreboard.sv
// Register-hazard scoreboard: tracks pending destinations of in-flight
// instructions, gates issue on RAW/WAW/structural hazards, flags bypasses.
module rv_scoreboard
  import rv_core_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_flush,
  input  logic                i_issue_vld,
  output logic                o_issue_rdy,
  input  fu_idx_t             i_issue_fu,
  input  reg_idx_t            i_issue_rd,
  input  logic                i_issue_rd_wren,
  input  reg_idx_t            i_issue_rs1,
  input  logic                i_issue_rs1_en,
  input  reg_idx_t            i_issue_rs2,
  input  logic                i_issue_rs2_en,
  input  logic [NUM_FU-1:0]   i_wb_vld,
  output logic [NUM_FU-1:0]   o_fu_busy,
  output logic [NUM_REGS-1:0] o_reg_pend,
  output logic                o_rs1_byp,
  output fu_idx_t             o_rs1_byp_fu,
  output logic                o_rs2_byp,
  output fu_idx_t             o_rs2_byp_fu
);

  logic [NUM_FU-1:0]   w_busy;
  logic [NUM_FU-1:0]   w_wr;
  logic [NUM_FU-1:0]   w_set;
  logic [NUM_FU-1:0]   w_wb_fire;
  reg_idx_t            w_dst [NUM_FU];
  logic [NUM_REGS-1:0] r_pend;
  fu_idx_t             r_owner [NUM_REGS];
  logic [NUM_REGS-1:0] w_eff_pend;
  logic [NUM_REGS-1:0] w_clr;
  logic                w_issue_wr;
  logic                w_accept;
  logic                w_rs1_hit;
  logic                w_rs2_hit;

  // A writeback only counts when the FU actually holds an instruction.
  assign w_wb_fire  = i_wb_vld & w_busy;
  assign w_issue_wr = i_issue_rd_wren & (i_issue_rd != '0);
  assign w_accept   = i_issue_vld & o_issue_rdy;

  for (genvar k = 0; k < NUM_FU; k++) begin : g_slot
    assign w_set[k] = w_accept & (i_issue_fu == fu_idx_t'(k));

    sb_fu_slot u_slot (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_flush  (i_flush),
      .i_set    (w_set[k]),
      .i_set_rd (i_issue_rd),
      .i_set_wr (w_issue_wr),
      .i_wb     (w_wb_fire[k]),
      .o_busy   (w_busy[k]),
      .o_dst    (w_dst[k]),
      .o_wr     (w_wr[k])
    );
  end

  // Only the current owner's writeback releases a register; older writers were overtaken.
  // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latch).
  always_comb begin
    w_eff_pend = '0;
    w_clr      = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      w_eff_pend[r] = r_pend[r] & ~w_wb_fire[r_owner[r]];
      w_clr[r]      = w_wb_fire[r_owner[r]] & w_wr[r_owner[r]]
                    & (w_dst[r_owner[r]] == reg_idx_t'(r));
    end
  end

  assign o_issue_rdy = ~i_flush
                     & ~(w_busy[i_issue_fu] & ~i_wb_vld[i_issue_fu])
                     & ~(i_issue_rs1_en & w_eff_pend[i_issue_rs1])
                     & ~(i_issue_rs2_en & w_eff_pend[i_issue_rs2])
                     & ~(w_issue_wr & w_eff_pend[i_issue_rd]);

  assign w_rs1_hit = i_issue_rs1_en & (i_issue_rs1 != '0) & r_pend[i_issue_rs1]
                   & w_wb_fire[r_owner[i_issue_rs1]];
  assign w_rs2_hit = i_issue_rs2_en & (i_issue_rs2 != '0) & r_pend[i_issue_rs2]
                   & w_wb_fire[r_owner[i_issue_rs2]];

  assign o_rs1_byp    = w_rs1_hit;
  assign o_rs1_byp_fu = w_rs1_hit ? r_owner[i_issue_rs1] : '0;
  assign o_rs2_byp    = w_rs2_hit;
  assign o_rs2_byp_fu = w_rs2_hit ? r_owner[i_issue_rs2] : '0;

  // NOTE: the owner table is reset explicitly so bypass indices are defined from the first cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pend <= '0;
      for (int r = 0; r < NUM_REGS; r++) r_owner[r] <= '0;
    end else if (i_flush) begin
      r_pend <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (w_accept && w_issue_wr && (i_issue_rd == reg_idx_t'(r))) begin
          r_pend[r]  <= 1'b1;
          r_owner[r] <= i_issue_fu;
        end else if (w_clr[r]) begin
          r_pend[r] <= 1'b0;
        end
      end
    end
  end

  assign o_fu_busy  = w_busy;
  assign o_reg_pend = {r_pend[NUM_REGS-1:1], 1'b0};

endmodule
